// File: rtl/jkff_bank.sv
// Bank of WIDTH JK-style flip-flops with run-time JK/D/T/SR mode and parallel load.
// Latency: one clock from any input to q/qbar/changed/sr_err/chg_cnt; no comb paths.
// Backpressure: none; the bank accepts new inputs on every rising edge.
//
// Ports:
//   i_clk        clock, rising-edge
//   i_rst_n      asynchronous active-low reset
//   i_en         mode-update enable (ignored while i_load=1)
//   i_mode       0=JK, 1=D, 2=T, 3=SR
//   i_load       parallel load strobe (highest priority)
//   i_load_data  parallel load value
//   i_j          per-bit J / D / T / S input
//   i_k          per-bit K / R input (unused in D and T modes)
//   i_err_clr    clears the sticky SR error flag
//   i_cnt_clr    clears the change-event counter
//   o_q          register state
//   o_qbar       registered complement of o_q
//   o_changed    bits that changed on the last edge
//   o_sr_err     sticky flag: illegal SR combination seen
//   o_chg_cnt    saturating count of edges on which q changed
module jkff_bank #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}},
  parameter int                 CNT_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic [WIDTH-1:0] i_j,
  input  logic [WIDTH-1:0] i_k,
  input  logic             i_err_clr,
  input  logic             i_cnt_clr,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qbar,
  output logic [WIDTH-1:0] o_changed,
  output logic             o_sr_err,
  output logic [CNT_W-1:0] o_chg_cnt
);

  localparam logic [1:0] MODE_JK = 2'd0;
  localparam logic [1:0] MODE_D  = 2'd1;
  localparam logic [1:0] MODE_T  = 2'd2;
  localparam logic [1:0] MODE_SR = 2'd3;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qbar;
  logic [WIDTH-1:0] r_changed;
  logic             r_sr_err;
  logic [CNT_W-1:0] r_chg_cnt;

  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_diff;
  logic             w_sr_set;

  // Per-bit next state. Every case statement falls back to hold in its
  // default arm, so any X/Z on j/k (or mode) leaves the bit unchanged.
  always_comb begin
    w_q_nxt = r_q;
    if (i_load) begin
      w_q_nxt = i_load_data;
    end else if (i_en) begin
      for (int b = 0; b < WIDTH; b++) begin
        case (i_mode)
          MODE_JK: begin
            case ({i_j[b], i_k[b]})
              2'b01:   w_q_nxt[b] = 1'b0;
              2'b10:   w_q_nxt[b] = 1'b1;
              2'b11:   w_q_nxt[b] = ~r_q[b];
              default: w_q_nxt[b] = r_q[b];
            endcase
          end
          MODE_D: begin
            case (i_j[b])
              1'b0:    w_q_nxt[b] = 1'b0;
              1'b1:    w_q_nxt[b] = 1'b1;
              default: w_q_nxt[b] = r_q[b];
            endcase
          end
          MODE_T: begin
            case (i_j[b])
              1'b1:    w_q_nxt[b] = ~r_q[b];
              default: w_q_nxt[b] = r_q[b];
            endcase
          end
          MODE_SR: begin
            // 11 is illegal and holds the bit; it is flagged via w_sr_set.
            case ({i_j[b], i_k[b]})
              2'b01:   w_q_nxt[b] = 1'b0;
              2'b10:   w_q_nxt[b] = 1'b1;
              default: w_q_nxt[b] = r_q[b];
            endcase
          end
          default: w_q_nxt[b] = r_q[b];
        endcase
      end
    end
  end

  assign w_diff   = r_q ^ w_q_nxt;
  assign w_sr_set = ~i_load & i_en & (i_mode == MODE_SR) & (|(i_j & i_k));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q       <= RST_VAL;
      r_qbar    <= ~RST_VAL;
      r_changed <= '0;
      r_sr_err  <= 1'b0;
      r_chg_cnt <= '0;
    end else begin
      r_q       <= w_q_nxt;
      r_qbar    <= ~w_q_nxt;
      r_changed <= w_diff;

      // Set has priority over clear so a concurrent illegal combo is never lost.
      if (w_sr_set) begin
        r_sr_err <= 1'b1;
      end else if (i_err_clr) begin
        r_sr_err <= 1'b0;
      end

      // Clear beats increment; increment saturates at all-ones.
      if (i_cnt_clr) begin
        r_chg_cnt <= '0;
      end else if ((|w_diff) && (r_chg_cnt != {CNT_W{1'b1}})) begin
        r_chg_cnt <= r_chg_cnt + CNT_W'(1);
      end
    end
  end

  assign o_q       = r_q;
  assign o_qbar    = r_qbar;
  assign o_changed = r_changed;
  assign o_sr_err  = r_sr_err;
  assign o_chg_cnt = r_chg_cnt;

endmodule

// File: tb/tb_jkff_bank.sv
module tb_jkff_bank;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_data;
  logic [7:0] j;
  logic [7:0] k;
  logic       err_clr;
  logic       cnt_clr;

  logic [7:0] q_a, qbar_a, chg_a;
  logic       err_a;
  logic [7:0] cnt_a;

  logic [7:0] q_b, qbar_b, chg_b;
  logic       err_b;
  logic [1:0] cnt_b;

  int checks;
  int failures;

  jkff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(8)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_load(load),
    .i_load_data(load_data), .i_j(j), .i_k(k), .i_err_clr(err_clr),
    .i_cnt_clr(cnt_clr), .o_q(q_a), .o_qbar(qbar_a), .o_changed(chg_a),
    .o_sr_err(err_a), .o_chg_cnt(cnt_a)
  );

  jkff_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_load(load),
    .i_load_data(load_data), .i_j(j), .i_k(k), .i_err_clr(err_clr),
    .i_cnt_clr(cnt_clr), .o_q(q_b), .o_qbar(qbar_b), .o_changed(chg_b),
    .o_sr_err(err_b), .o_chg_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    en = 1'b0; mode = 2'd0; load = 1'b0; load_data = 8'h00;
    j = 8'h00; k = 8'h00; err_clr = 1'b0; cnt_clr = 1'b0;
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
    // Build up non-reset state: loaded value, counter and sticky error.
    load = 1'b1; load_data = 8'h33;
    step();
    idle();
    en = 1'b1; mode = 2'd3; j = 8'h01; k = 8'h01;
    step();
    idle();
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL pre_reset_err got=%b exp=1", err_a); end
    // Assert reset mid-cycle and check before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q_a !== 8'hA5) begin failures++; $display("FAIL reset_q got=%h exp=a5", q_a); end
    checks++; if (qbar_a !== 8'h5A) begin failures++; $display("FAIL reset_qbar got=%h exp=5a", qbar_a); end
    checks++; if (chg_a !== 8'h00) begin failures++; $display("FAIL reset_changed got=%h exp=00", chg_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_a); end
    checks++; if (cnt_a !== 8'h00) begin failures++; $display("FAIL reset_cnt got=%h exp=00", cnt_a); end
    // Reset holds across a clock edge even with live inputs.
    load = 1'b1; load_data = 8'hFF;
    step();
    checks++; if (q_a !== 8'hA5) begin failures++; $display("FAIL reset_hold_q got=%h exp=a5", q_a); end
    idle();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_jk();
    // Load 00 with concurrent cnt_clr: clear beats the increment.
    load = 1'b1; load_data = 8'h00; cnt_clr = 1'b1;
    step();
    idle();
    checks++; if (cnt_a !== 8'h00) begin failures++; $display("FAIL jk_pre_cnt got=%h exp=00", cnt_a); end
    en = 1'b1; mode = 2'd0; j = 8'hF0; k = 8'h0F;
    step();
    checks++; if (q_a !== 8'hF0) begin failures++; $display("FAIL jk_set_q got=%h exp=f0", q_a); end
    checks++; if (chg_a !== 8'hF0) begin failures++; $display("FAIL jk_set_changed got=%h exp=f0", chg_a); end
    checks++; if (qbar_a !== 8'h0F) begin failures++; $display("FAIL jk_set_qbar got=%h exp=0f", qbar_a); end
    j = 8'hFF; k = 8'hFF;
    step();
    checks++; if (q_a !== 8'h0F) begin failures++; $display("FAIL jk_toggle_q got=%h exp=0f", q_a); end
    checks++; if (chg_a !== 8'hFF) begin failures++; $display("FAIL jk_toggle_changed got=%h exp=ff", chg_a); end
    checks++; if (cnt_a !== 8'h02) begin failures++; $display("FAIL jk_toggle_cnt got=%h exp=02", cnt_a); end
  endtask

  task automatic test_d_t_hold();
    mode = 2'd1; j = 8'h3C; k = 8'hFF;
    step();
    checks++; if (q_a !== 8'h3C) begin failures++; $display("FAIL d_q got=%h exp=3c", q_a); end
    checks++; if (chg_a !== 8'h33) begin failures++; $display("FAIL d_changed got=%h exp=33", chg_a); end
    mode = 2'd2; j = 8'h81; k = 8'h00;
    step();
    checks++; if (q_a !== 8'hBD) begin failures++; $display("FAIL t_q got=%h exp=bd", q_a); end
    checks++; if (cnt_a !== 8'h04) begin failures++; $display("FAIL t_cnt got=%h exp=04", cnt_a); end
    en = 1'b0; j = 8'hFF;
    step();
    checks++; if (q_a !== 8'hBD) begin failures++; $display("FAIL hold_q got=%h exp=bd", q_a); end
    checks++; if (chg_a !== 8'h00) begin failures++; $display("FAIL hold_changed got=%h exp=00", chg_a); end
    checks++; if (cnt_a !== 8'h04) begin failures++; $display("FAIL hold_cnt got=%h exp=04", cnt_a); end
    // Unknown j in JK mode holds every bit.
    en = 1'b1; mode = 2'd0; j = 8'hxx; k = 8'h00;
    step();
    checks++; if (q_a !== 8'hBD) begin failures++; $display("FAIL xj_q got=%h exp=bd", q_a); end
    checks++; if (chg_a !== 8'h00) begin failures++; $display("FAIL xj_changed got=%h exp=00", chg_a); end
    idle();
  endtask

  task automatic test_sr();
    load = 1'b1; load_data = 8'h00;
    step();
    idle();
    en = 1'b1; mode = 2'd3; j = 8'h0F; k = 8'h03;
    step();
    checks++; if (q_a !== 8'h0C) begin failures++; $display("FAIL sr_q got=%h exp=0c", q_a); end
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL sr_err_set got=%b exp=1", err_a); end
    j = 8'h10; k = 8'h10; err_clr = 1'b1;
    step();
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL sr_set_wins got=%b exp=1", err_a); end
    checks++; if (q_a !== 8'h0C) begin failures++; $display("FAIL sr_illegal_hold got=%h exp=0c", q_a); end
    en = 1'b0; j = 8'h00; k = 8'h00;
    step();
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL sr_err_clr got=%b exp=0", err_a); end
    err_clr = 1'b0; en = 1'b1; j = 8'h00; k = 8'h04;
    step();
    checks++; if (q_a !== 8'h08) begin failures++; $display("FAIL sr_reset_q got=%h exp=08", q_a); end
    idle();
  endtask

  task automatic test_load();
    load = 1'b1; load_data = 8'h55; en = 1'b0; mode = 2'd3; j = 8'hFF; k = 8'hFF;
    step();
    checks++; if (q_a !== 8'h55) begin failures++; $display("FAIL load_q got=%h exp=55", q_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL load_err got=%b exp=0", err_a); end
    checks++; if (chg_a !== 8'h5D) begin failures++; $display("FAIL load_changed got=%h exp=5d", chg_a); end
    checks++; if (qbar_a !== 8'hAA) begin failures++; $display("FAIL load_qbar got=%h exp=aa", qbar_a); end
    idle();
  endtask

  task automatic test_saturate();
    logic [1:0] exp_b [5];
    exp_b[0] = 2'd1; exp_b[1] = 2'd2; exp_b[2] = 2'd3; exp_b[3] = 2'd3; exp_b[4] = 2'd3;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++; if (cnt_b !== 2'd0) begin failures++; $display("FAIL sat_pre_cnt got=%0d exp=0", cnt_b); end
    en = 1'b1; mode = 2'd0; j = 8'hFF; k = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (cnt_b !== exp_b[i]) begin
        failures++; $display("FAIL sat_cnt_edge%0d got=%0d exp=%0d", i, cnt_b, exp_b[i]);
      end
    end
    checks++; if (cnt_a !== 8'd5) begin failures++; $display("FAIL wide_cnt got=%0d exp=5", cnt_a); end
    cnt_clr = 1'b1;
    step();
    checks++; if (cnt_b !== 2'd0) begin failures++; $display("FAIL sat_clr_cnt got=%0d exp=0", cnt_b); end
    checks++; if (chg_b !== 8'hFF) begin failures++; $display("FAIL sat_clr_changed got=%h exp=ff", chg_b); end
    checks++; if (qbar_b !== ~q_b) begin failures++; $display("FAIL sat_qbar got=%h q=%h", qbar_b, q_b); end
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_jk();
    test_d_t_hold();
    test_sr();
    test_load();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jkff_bank.md
Name: jkff_bank

Overview:
- Parametrised, multi-mode successor to the single JK flip-flop: a WIDTH-bit register bank where every bit is a JK-style flip-flop with its own J/K inputs.
- A run-time mode selects JK, D, T or SR semantics for all bits; a parallel load overrides the mode.
- Adds per-bit change flags, a sticky SR-illegal error flag and a saturating change-event counter.
- Used as a general-purpose state/flag register in control datapaths.

Parameters:
- WIDTH, 8, number of flip-flops in the bank (>=1).
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- CNT_W, 8, width of the change-event counter (>=1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  mode-update enable; ignored when load=1.
- mode  in  2  0=JK, 1=D, 2=T, 3=SR.
- load  in  1  parallel load strobe.
- load_data  in  WIDTH  parallel load value.
- j  in  WIDTH  per-bit J / D / T / S input, depending on mode.
- k  in  WIDTH  per-bit K / R input; ignored in D and T modes.
- err_clr  in  1  clears sr_err.
- cnt_clr  in  1  clears chg_cnt.
- q  out  WIDTH  register state.
- qbar  out  WIDTH  always the bitwise complement of q.
- changed  out  WIDTH  bits of q that changed on the last clock edge.
- sr_err  out  1  sticky flag: an illegal SR combination was presented.
- chg_cnt  out  CNT_W  saturating count of edges on which q changed.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately regardless of clk):
  - q=RST_VAL, qbar=~RST_VAL.
  - changed=0, sr_err=0, chg_cnt=0.
  - Holds while rst=0. The first update happens on the first rising clk edge after rst goes high.
- Next-state q_nxt is computed per bit, in this priority order:
  1. load=1 -> q_nxt=load_data (mode, en, j, k ignored).
  2. en=0 -> hold.
  3. mode JK: jk=00 hold, 01 clear, 10 set, 11 toggle.
  4. mode D: q_nxt=j.
  5. mode T: j=1 toggle, j=0 hold.
  6. mode SR: 00 hold, 01 clear, 10 set, 11 illegal -> hold that bit.
- X/Z on j/k never propagates: any non-0/1 combination holds the bit. The outputs never drive z.
- On every rising edge with rst=1:
  - q <= q_nxt.
  - qbar <= ~q_nxt; qbar is registered, never combinational from q.
- changed <= q ^ q_nxt, registered on the same edge, so changed is valid in the same cycle as the new q. It reads 0 on an edge with no change, including hold.
- sr_err:
  - Set on an edge where load=0, en=1, mode=SR and any bit has j=k=1.
  - Cleared on an edge with err_clr=1. If set and clear occur on the same edge, set wins.
  - Otherwise holds.
- chg_cnt:
  - Increments by 1 on an edge where |(q ^ q_nxt)=1.
  - Saturates at all-ones and does not wrap.
  - cnt_clr=1 forces it to 0, with priority over increment.
- Latency: one clock from inputs to q/qbar/changed/sr_err/chg_cnt. No combinational input-to-output paths.
- A mode change takes effect on the same edge as the new mode value; there is no pipeline.
- Reset asserted mid-operation discards all state, including the sticky error and the counter.

Test Plan:
- Reset with RST_VAL=8'hA5, rst=0 asynchronously mid-cycle -> q=A5, qbar=5A, changed=00, sr_err=0, chg_cnt=0 immediately, before the next clk edge.
- JK mode, en=1, q=00, j=F0, k=0F -> q=F0, changed=F0. Then j=FF, k=FF -> q=0F, changed=FF, chg_cnt=2.
- D mode, j=3C -> q=3C. T mode, j=81 -> q=BD. en=0 with j=FF -> q holds BD, changed=00, chg_cnt unchanged.
- SR mode, q=00, j=0F, k=03 -> bits 1:0 illegal and hold 0, bits 3:2 set -> q=0C, sr_err=1. Apply err_clr=1 together with another illegal combo -> sr_err stays 1. Then err_clr alone -> sr_err=0.
- load=1, load_data=55, en=0, mode=SR, j=k=FF -> q=55, sr_err not set.
- CNT_W=2: toggle all bits (JK mode, j=k=FF) for 5 edges -> chg_cnt=3 and stays 3. cnt_clr with a concurrent change -> chg_cnt=0.
